div_share_sched: RTL and testbench

- Round-robin scheduler that shares one combinational long_divider (7-bit dividend, 4-bit divisor, 4-bit quotient and remainder) among NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the divider operands from registers.
- Waits a fixed settle time, captures Q/R, and returns them on a single tagged response channel.
- Sits between the client blocks and the single divider instance.

---
 rtl/div_share_sched_pkg.sv | 20 ++
 rtl/div_rr_arbiter.sv | 29 ++
 rtl/div_share_sched.sv | 125 ++++++++++++
 tb/tb_div_share_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_share_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
package div_share_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_DW = 7;
  localparam int DEF_MW = 4;

  // Quotient reported for a rejected operation; sliced to MW by the user.
  localparam logic [31:0] ERR_QUOT = '1;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module div_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          hit
);

  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!hit && req[k]) begin
        hit     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Shares one combinational divider among NUM_REQ clients, one operation at a time.
// Build option: define DIV_SHARE_SCHED_ERRCHK_EN to reject divide-by-zero/overflow at accept.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready shows the round-robin winner
// SETTLE | operands held on the divider for SETTLE_CYCLES cycles
// RESP   | tagged result presented until the consumer takes it
module div_share_sched
  import div_share_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DW            = DEF_DW,
  parameter int MW            = DEF_MW,
  parameter int SETTLE_CYCLES = 1,
  localparam int IW           = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_dividend,
  input  logic [NUM_REQ*MW-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [MW-1:0]         rsp_q,
  output logic [MW-1:0]         rsp_r,
  output logic                  rsp_err,
  output logic [DW-1:0]         div_d,
  output logic [MW-1:0]         div_m,
  input  logic [MW-1:0]         div_q,
  input  logic [MW-1:0]         div_r,
  output logic                  busy
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  state_t            state, state_nx;
  logic [IW-1:0]     ptr, gnt_idx, id_q, ptr_nx;
  logic [NUM_REQ-1:0] gnt;
  logic              hit, acc, acc_err;
  logic [DW-1:0]     sel_d;
  logic [MW-1:0]     sel_m;
  logic [CW-1:0]     cnt;

  div_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .hit     (hit)
  );

  assign sel_d  = req_dividend[gnt_idx*DW +: DW];
  assign sel_m  = req_divisor[gnt_idx*MW +: MW];
  assign acc    = (state == IDLE) && hit;
  assign ptr_nx = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef DIV_SHARE_SCHED_ERRCHK_EN
  localparam int EW = DW + MW;
  // Quotient would not fit in MW bits when dividend >= divisor << MW.
  assign acc_err = (sel_m == '0) || (EW'(sel_d) >= (EW'(sel_m) << MW));
`else
  assign acc_err = 1'b0;
`endif

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = acc_err ? RESP : SETTLE;
      SETTLE:  if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      id_q    <= '0;
      cnt     <= '0;
      div_d   <= '0;
      div_m   <= '0;
      rsp_id  <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (acc) begin
        ptr   <= ptr_nx;
        id_q  <= gnt_idx;
        div_d <= sel_d;
        div_m <= sel_m;
        cnt   <= CW'(SETTLE_CYCLES - 1);
        if (acc_err) begin
          rsp_id  <= gnt_idx;
          rsp_q   <= ERR_QUOT[MW-1:0];
          rsp_r   <= '0;
          rsp_err <= 1'b1;
        end
      end
      // Settle timer counts down; capture divider output at terminal count.
      if (state == SETTLE) begin
        if (cnt == '0) begin
          rsp_id  <= id_q;
          rsp_q   <= div_q;
          rsp_r   <= div_r;
          rsp_err <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a behavioural divider attached.
module tb_div_share_sched;

  localparam int N  = 4;
  localparam int DW = 7;
  localparam int MW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dividend = '0;
  logic [N*MW-1:0] req_divisor = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [MW-1:0]   rsp_q, rsp_r;
  logic            rsp_err;
  logic [DW-1:0]   div_d;
  logic [MW-1:0]   div_m, div_q, div_r;
  logic            busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Divider model: by-zero returns all-ones quotient and the low dividend bits.
  assign div_q = (div_m == '0) ? 4'hF : 4'(div_d / div_m);
  assign div_r = (div_m == '0) ? div_d[3:0] : 4'(div_d % div_m);

  div_share_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_q        (rsp_q),
    .rsp_r        (rsp_r),
    .rsp_err      (rsp_err),
    .div_d        (div_d),
    .div_m        (div_m),
    .div_q        (div_q),
    .div_r        (div_r),
    .busy         (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int d, input int m);
    req_dividend[i*DW +: DW] = DW'(d);
    req_divisor[i*MW +: MW]  = MW'(m);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0] all_outs;
  assign all_outs = {req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_d, div_m, busy};

  int exp_q[4] = '{3, 2, 2, 3};
  int exp_r[4] = '{0, 1, 2, 1};
  logic seen;

  initial begin
    #1;
    check_val("reset_outs", all_outs, 32'h0);
    do_reset();

    // Single request 7/2
    set_op(0, 7, 2);
    req_valid = 4'b0001;
    #1;
    check_val("t1_ready", {28'h0, req_ready}, 32'h1);
    tick();
    check_val("t1_settle", {req_ready, rsp_valid, busy, div_d, div_m}, {4'b0000, 1'b0, 1'b1, 7'd7, 4'd2});
    req_valid = '0;
    tick();
    check_val("t1_rsp", {rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err}, {1'b1, 2'd0, 4'd3, 4'd1, 1'b0});
    rsp_ready = 1'b1;
    tick();
    check_val("t1_idle", {rsp_valid, busy}, 2'b00);

    // Four simultaneous requests answered in id order
    do_reset();
    set_op(0, 6, 2); set_op(1, 9, 4); set_op(2, 12, 5); set_op(3, 7, 2);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      check_val($sformatf("t2_ready%0d", n), {28'h0, req_ready}, 32'(1 << n));
      tick();
      req_valid[n] = 1'b0;
      tick();
      check_val($sformatf("t2_rsp%0d", n), {rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err},
                {1'b1, 2'(n), 4'(exp_q[n]), 4'(exp_r[n]), 1'b0});
      tick();
    end

    // Backpressure on the response channel
    do_reset();
    set_op(1, 13, 3);
    req_valid = 4'b0010;
    #1;
    check_val("t3_ready", {28'h0, req_ready}, 32'h2);
    tick();
    set_op(2, 10, 3);
    req_valid = 4'b0100;
    tick();
    check_val("t3_rsp", {rsp_valid, rsp_id, rsp_q, rsp_r}, {1'b1, 2'd1, 4'd4, 4'd1});
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val($sformatf("t3_hold%0d", c), {rsp_valid, rsp_id, rsp_q, rsp_r, req_ready, busy},
                {1'b1, 2'd1, 4'd4, 4'd1, 4'b0000, 1'b1});
    end
    rsp_ready = 1'b1;
    tick();
    check_val("t3_release", {rsp_valid, busy, req_ready}, {1'b0, 1'b0, 4'b0100});

    // Continuously valid requester 0 must alternate with requester 2
    do_reset();
    set_op(0, 7, 2); set_op(2, 9, 4);
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check_val($sformatf("t4_grant%0d", g), {28'h0, req_ready}, (g % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      tick();
      check_val($sformatf("t4_rsp%0d", g), {rsp_valid, rsp_id, rsp_q},
                (g % 2 == 0) ? {1'b1, 2'd0, 4'd3} : {1'b1, 2'd2, 4'd2});
      tick();
    end

    // Divide-by-zero and overflow
    do_reset();
    set_op(0, 9, 0);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    check_val("t5_ops", {div_d, div_m}, {7'd9, 4'd0});
`ifdef DIV_SHARE_SCHED_ERRCHK_EN
    check_val("t5_dz", {rsp_valid, rsp_q, rsp_r, rsp_err}, {1'b1, 4'hF, 4'h0, 1'b1});
`else
    check_val("t5_dz_settle", {28'h0, rsp_valid, busy}, 32'h1);
    tick();
    check_val("t5_dz", {rsp_valid, rsp_q, rsp_r, rsp_err}, {1'b1, 4'hF, 4'h9, 1'b0});
`endif
    rsp_ready = 1'b1;
    tick();
    set_op(1, 100, 5);
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
`ifdef DIV_SHARE_SCHED_ERRCHK_EN
    check_val("t5_ovf", {rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err}, {1'b1, 2'd1, 4'hF, 4'h0, 1'b1});
`else
    tick();
    check_val("t5_ovf", {rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err}, {1'b1, 2'd1, 4'h4, 4'h0, 1'b0});
`endif
    tick();

    // Asynchronous reset in the middle of SETTLE
    do_reset();
    set_op(3, 11, 2);
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    check_val("t6_busy", {28'h0, busy, div_d[3:0] == 4'd11}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_clear", all_outs, 32'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | rsp_valid;
    end
    check_val("t6_no_rsp", {31'h0, seen}, 32'h0);
    set_op(1, 5, 5);
    set_op(3, 6, 3);
    req_valid = 4'b1010;
    #1;
    check_val("t6_ptr_reset", {28'h0, req_ready}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
